mtm_alu_deserializer: RTL
=========================

# mtm_alu_deserializer

Serial-to-parallel input stage of the mtm_Alu. It receives the 11-bit framed serial stream on `sin` and reassembles operands B and A plus the CTL byte. It checks frame count, CRC and opcode, then presents either a decoded operation or an error code to the ALU core for one cycle. The core's result serializer drives `sout` downstream of this block.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64: consecutive idle-high cycles between frames, mid-packet, that abort the packet; 0 disables the timeout.

Ports:
- `clk`  in  1  system clock; one serial bit per cycle.
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `sin`  in  1  serial input; idles high.
- `a`  out  32  operand A.
- `b`  out  32  operand B.
- `op`  out  3  opcode from CTL[6:4].
- `op_valid`  out  1  one-cycle pulse; `a`/`b`/`op` are valid in that cycle.
- `err_flags`  out  3  {ERR_DATA, ERR_CRC, ERR_OP}; exactly one bit set when an error is reported.
- `err_valid`  out  1  one-cycle pulse qualifying `err_flags`.

## Operation
- Frame: start `0`, flag (`0` = DATA, `1` = CTL), 8 payload bits MSB first, stop `1`.
- Packet order: 8 DATA frames carrying B[31:24], B[23:16], B[15:8], B[7:0], A[31:24], A[23:16], A[15:8], A[7:0], then 1 CTL frame = {0, OP[2:0], CRC[3:0]}.
- FSM states:
  - IDLE: on `sin`=0 go to FLAG.
  - FLAG: latch the flag bit, go to DATA.
  - DATA: 8 bits, counted 0..7, then go to STOP.
  - STOP: if `sin`=1, process the frame and return to IDLE.
  - STOP with `sin`=0 is a framing error: discard the whole packet (frame counter cleared, CRC cleared), produce no output, return to IDLE.
- DATA frame processing: shift the byte into a 64-bit {B,A} register; frame counter increments and saturates at 9.
- CTL frame processing is evaluated in the following priority order, and the counter and CRC are cleared afterwards in every case:
  - count ≠ 8 → ERR_DATA (`err_flags`=3'b100).
  - CRC mismatch → ERR_CRC (3'b010).
  - OP ∉ {000, 001, 100, 101} → ERR_OP (3'b001).
  - Otherwise → `op_valid` pulse.
- CRC:
  - Polynomial x^4+x+1, init 4'b0000.
  - Computed over the 68-bit stream {B, A, 1'b1, OP}, first bit B[31].
  - Updated serially as the bits arrive; no extra latency.
- Timeout: in IDLE with frame counter > 0, `TIMEOUT_CYCLES` consecutive `sin`=1 samples discard the packet silently. The timeout counter resets on every start bit.

## Timing
- All outputs reset to 0; FSM resets to IDLE; frame, bit, CRC and timeout counters reset to 0.
- Reset asserted mid-packet discards the packet; no pulse is produced.
- `sin` is sampled on the rising edge of `clk`.
- `op_valid`/`err_valid` assert in the cycle immediately after the edge that sampled the CTL stop bit, for exactly 1 cycle, and never both at once.
- `a`/`b`/`op` are registered and hold their values until the next `op_valid`. `err_flags` returns to 0 when `err_valid` drops.
- Back-to-back frames: a start bit sampled on the edge right after a stop bit is accepted (zero idle gap).
- Start bit to result: 99 edges for a minimal 9-frame packet, plus 1 cycle to the output pulse.
- A DATA frame arriving after 8 DATA frames is accepted into the shift register (oldest byte lost); the counter stays at 9, so the following CTL frame yields ERR_DATA.

## Configuration
- `MTM_ALU_DESER_CRC_EN` defined: CRC is computed and checked as above.
- `MTM_ALU_DESER_CRC_EN` undefined:
  - CRC logic is removed and CTL[3:0] is ignored.
  - ERR_CRC is never set.
  - The priority order reduces to ERR_DATA, then ERR_OP.

## Test plan
- B=2, A=4, CTL=0x02 (AND, CRC=4'b0010) → `op_valid` pulse with `a`=0x00000004, `b`=0x00000002, `op`=000.
- Same data, CTL=0x0F → `err_valid` with `err_flags`=3'b010 (macro defined); `err_flags`=3'b001 is not expected since OP=000; `op_valid` pulse when the macro is undefined.
- DATA 0x55, DATA 0x0F, then CTL 0x50 → `err_valid` with `err_flags`=3'b100; a valid packet sent immediately after returns `op_valid`.
- B=A=0xFFFFFFFF with OP 000/001/100/101 and correct CRC, then B=A=0 with the same ops → 8 `op_valid` pulses with operands intact; OP=010 with correct CRC → `err_flags`=3'b001.
- 1000 random A/B/op packets sent back-to-back (zero gap) → every decoded `a`/`b`/`op` matches the bench model; no `err_valid`.
- Stop bit forced to 0 in frame 3, `rst` pulsed in frame 5, and a 64-cycle idle gap after frame 4 → each packet is dropped silently; the next clean packet decodes correctly.

Source files
------------

// File: rtl/mtm_alu_deserializer.sv
// Serial input stage of the mtm_Alu: reassembles B, A and CTL from 11-bit frames and
// reports a decoded operation or an error. Define MTM_ALU_DESER_CRC_EN to enable CRC checking.
module mtm_alu_deserializer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [2:0]  op,
    output logic        op_valid,
    output logic [2:0]  err_flags,
    output logic        err_valid
);

    typedef enum logic [1:0] {IDLE, FLAG, DATA, STOP} state_t;

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t        state, state_next;
    logic [2:0]    bit_cnt;
    logic          flag;
    logic [7:0]    payload;
    logic [63:0]   operands;
    logic [3:0]    frame_cnt;
    logic [TW-1:0] tcnt;

    logic frame_done, frame_abort, ctl_done, timeout_hit, clear, crc_ok, op_legal;

    assign frame_done  = (state == STOP) && sin;
    assign frame_abort = (state == STOP) && !sin;
    assign ctl_done    = frame_done && flag;
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (state == IDLE) && sin &&
                         (frame_cnt != 4'd0) && (tcnt == T_LAST);
    assign clear       = frame_abort || ctl_done || timeout_hit;
    assign op_legal    = !payload[5];   // legal opcodes 000/001/100/101 all have bit 1 clear

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!sin) state_next = FLAG;
            FLAG:    state_next = DATA;
            DATA:    if (bit_cnt == 3'd7) state_next = STOP;
            STOP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef MTM_ALU_DESER_CRC_EN
    logic [3:0] crc;
    logic       crc_step, crc_bit;

    // CTL frames feed a constant 1 in place of CTL[7], then OP; the received CRC nibble is not fed.
    assign crc_step = (state == DATA) && (!flag || !bit_cnt[2]);
    assign crc_bit  = (flag && bit_cnt == 3'd0) ? 1'b1 : sin;
    assign crc_ok   = (crc == payload[3:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           crc <= 4'd0;
        else if (clear)    crc <= 4'd0;
        else if (crc_step) crc <= {crc[2:0], 1'b0} ^ {2'b00, {2{crc[3] ^ crc_bit}}};
    end
`else
    assign crc_ok = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= 3'd0;
            flag      <= 1'b0;
            payload   <= 8'd0;
            operands  <= 64'd0;
            frame_cnt <= 4'd0;
            tcnt      <= '0;
            a         <= 32'd0;
            b         <= 32'd0;
            op        <= 3'd0;
            op_valid  <= 1'b0;
            err_valid <= 1'b0;
            err_flags <= 3'd0;
        end else begin
            op_valid  <= 1'b0;
            err_valid <= 1'b0;
            err_flags <= 3'd0;

            if (state == IDLE) begin
                if (!sin)                   tcnt <= '0;
                else if (frame_cnt != 4'd0) tcnt <= timeout_hit ? '0 : tcnt + 1'b1;
            end

            if (state == FLAG) flag <= sin;

            if (state == DATA) begin
                payload <= {payload[6:0], sin};
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (frame_done && !flag) begin
                operands <= {operands[55:0], payload};
                if (frame_cnt != 4'd9) frame_cnt <= frame_cnt + 4'd1;
            end

            if (ctl_done) begin
                if (frame_cnt != 4'd8) begin
                    err_valid <= 1'b1;
                    err_flags <= 3'b100;
                end else if (!crc_ok) begin
                    err_valid <= 1'b1;
                    err_flags <= 3'b010;
                end else if (!op_legal) begin
                    err_valid <= 1'b1;
                    err_flags <= 3'b001;
                end else begin
                    op_valid <= 1'b1;
                    b        <= operands[63:32];
                    a        <= operands[31:0];
                    op       <= payload[6:4];
                end
            end

            if (clear) frame_cnt <= 4'd0;
        end
    end

endmodule
